// File: rtl/clk_gate_sched.sv
// Clock-enable scheduler for a BUFGCE-gated region shared round-robin by N_REQ requesters.
// Wakes the region on demand, delays grants until WAKE_CYCLES edges have reached it, gates off after IDLE_CYCLES.
module clk_gate_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             ce,
  output logic [1:0]       state,
  input  logic             clr_cnt,
  output logic [15:0]      on_cnt
);

  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WCNT_W = $clog2(WAKE_CYCLES + 1);
  localparam int unsigned ICNT_W = $clog2(IDLE_CYCLES + 1);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_WAKE = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_IDLE = 2'd3;

  logic [1:0]       r_state,    w_state_nxt;
  logic             r_ce,       w_ce_nxt;
  logic [N_REQ-1:0] r_gnt,      w_gnt_nxt;
  logic [PTR_W-1:0] r_ptr,      w_ptr_nxt;
  logic [WCNT_W-1:0] r_wake_cnt, w_wake_nxt;
  logic [ICNT_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [15:0]      r_on_cnt,   w_on_nxt;

  logic             w_win_vld;
  logic [PTR_W-1:0] w_win_idx;
  logic [N_REQ-1:0] w_win_oh;

  // Round-robin winner: first requester after the last granted index, wrapping.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      if (!w_win_vld && req[PTR_W'((32'(r_ptr) + k) % N_REQ)]) begin
        w_win_vld = 1'b1;
        w_win_idx = PTR_W'((32'(r_ptr) + k) % N_REQ);
      end
    end
    w_win_oh            = '0;
    w_win_oh[w_win_idx] = w_win_vld;
  end

  // Next-state logic; gnt only ever leaves zero on an edge that also lands in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = r_ce;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_wake_nxt  = r_wake_cnt;
    w_idle_nxt  = r_idle_cnt;
    case (r_state)
      S_OFF: begin
        w_ce_nxt = 1'b0;
        if (|req) begin
          w_state_nxt = S_WAKE;
          w_ce_nxt    = 1'b1;
          w_wake_nxt  = '0;
        end
      end
      S_WAKE: begin
        w_ce_nxt   = 1'b1;
        w_wake_nxt = r_wake_cnt + 1'b1;
        if (r_wake_cnt == WCNT_W'(WAKE_CYCLES - 1)) begin
          w_state_nxt = S_RUN;
          w_gnt_nxt   = w_win_oh;
          if (w_win_vld) w_ptr_nxt = w_win_idx;
        end
      end
      S_RUN: begin
        w_ce_nxt = 1'b1;
        if (|r_gnt) begin
          if (~|(r_gnt & req)) w_gnt_nxt = '0;
        end else if (w_win_vld) begin
          w_gnt_nxt = w_win_oh;
          w_ptr_nxt = w_win_idx;
        end else begin
          w_state_nxt = S_IDLE;
          w_idle_nxt  = '0;
        end
      end
      S_IDLE: begin
        w_ce_nxt = 1'b1;
        if (w_win_vld) begin
          w_state_nxt = S_RUN;
          w_gnt_nxt   = w_win_oh;
          w_ptr_nxt   = w_win_idx;
        end else if (r_idle_cnt == ICNT_W'(IDLE_CYCLES - 1)) begin
          w_state_nxt = S_OFF;
          w_ce_nxt    = 1'b0;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_ce_nxt    = 1'b0;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // Enabled-cycle counter: clear wins over increment, saturates at all-ones.
  always_comb begin
    w_on_nxt = r_on_cnt;
    if (clr_cnt)                          w_on_nxt = '0;
    else if (r_ce && r_on_cnt != 16'hFFFF) w_on_nxt = r_on_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_OFF;
      r_ce       <= 1'b0;
      r_gnt      <= '0;
      r_ptr      <= PTR_W'(N_REQ - 1);
      r_wake_cnt <= '0;
      r_idle_cnt <= '0;
      r_on_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ce       <= w_ce_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_on_cnt   <= w_on_nxt;
    end
  end

  assign gnt    = r_gnt;
  assign ce     = r_ce;
  assign state  = r_state;
  assign on_cnt = r_on_cnt;

endmodule
